// File: rtl/fir_ctrl_pkg.sv
// Shared types and helpers for the time-multiplexed FIR sequencer.
// Holds the FSM state enum, accumulator width derivation and saturation.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    // Full-precision product plus log2(N) guard bits for the tap sum.
    function automatic int acc_w(input int width, input int n);
        return 2 * width + $clog2(n);
    endfunction

    // Clamp to the signed range of a width-bit word; caller keeps the
    // low width bits of the result.
    function automatic logic signed [63:0] sat_w(
        input logic signed [63:0] v,
        input int                 width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample/result handshake and coefficient bus for fir_mac_sequencer.
// master: source/consumer side; slave: the sequencer.
interface fir_mac_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int N     = 4
);
    localparam int AW = $clog2(N);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] Xn;
    logic                    out_valid;
    logic signed [WIDTH-1:0] Yn;
    logic                    coef_we;
    logic [AW-1:0]           coef_addr;
    logic signed [WIDTH-1:0] coef_data;
    logic                    coef_err;
    logic                    busy;

    modport master (
        output in_valid, Xn, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, Yn, coef_err, busy
    );

    modport slave (
        input  in_valid, Xn, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, Yn, coef_err, busy
    );

endinterface

// File: rtl/fir_mac.sv
// Shared signed multiply-accumulate unit.
// Ports: clr zeroes the sum, en adds a*b; acc is the sum including this cycle's product.
module fir_mac #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 34
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [ACC_W-1:0] acc
);
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_x;
    logic signed [ACC_W-1:0]   acc_q;

    assign prod   = a * b;
    assign prod_x = ACC_W'(prod);
    // Exposing the running sum lets the last tap be scaled on its own edge.
    assign acc    = acc_q + (en ? prod_x : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc;
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed N-tap FIR: one MAC swept over a sample ring buffer.
// Ports: clk, rst_n, bus (slave: Xn in, Yn out, coefficient writes, busy).
module fir_mac_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fir_mac_sequencer_if.slave   bus
);
    localparam int ACC_W = acc_w(WIDTH, N);
    localparam int AW    = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);
    localparam logic signed [WIDTH-1:0] C_ONE = {1'b0, {(WIDTH-1){1'b1}}};

    state_t                  state;
    logic [AW-1:0]           k;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           wr_nxt;
    logic [AW-1:0]           rd_idx;
    logic                    rdy_q;
    logic                    ov_q;
    logic                    busy_q;
    logic                    err_q;
    logic signed [WIDTH-1:0] yn_q;
    logic signed [WIDTH-1:0] yn_d;
    logic signed [WIDTH-1:0] sbuf [N];
    logic signed [WIDTH-1:0] coef [N];
    logic                    accept;
    logic                    addr_ok;
    logic                    coef_ok;
    logic                    in_mac;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sh;
    logic signed [63:0]      acc_x;

    assign bus.in_ready  = rst_n & rdy_q;
    assign bus.out_valid = ov_q;
    assign bus.Yn        = yn_q;
    assign bus.coef_err  = err_q;
    assign bus.busy      = busy_q;

    assign accept = bus.in_valid & bus.in_ready;
    assign in_mac = (state == MAC);

    generate
        if ((1 << AW) == N) begin : g_addr_p2
            assign addr_ok = 1'b1;
        end else begin : g_addr_np2
            assign addr_ok = int'(bus.coef_addr) < N;
        end
    endgenerate

    assign coef_ok = bus.coef_we & addr_ok & ~in_mac;
    assign wr_nxt  = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;

    // Tap k reads the sample k steps older than the newest one.
    always_comb begin : rd_index
        int t;
        t = int'(wr_ptr) - int'(k);
        if (t < 0) t = t + N;
        rd_idx = AW'(t);
    end

    fir_mac #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (in_mac),
        .a     (coef[k]),
        .b     (sbuf[rd_idx]),
        .acc   (acc)
    );

    assign acc_sh = acc >>> (WIDTH - 1);
    assign acc_x  = 64'(acc_sh);
    assign yn_d   = WIDTH'(sat_w(acc_x, WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                sbuf[i] <= '0;
                coef[i] <= (i == 0) ? C_ONE : '0;
            end
        end else begin
            if (accept) sbuf[wr_nxt] <= bus.Xn;
            if (coef_ok) coef[bus.coef_addr] <= bus.coef_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            k      <= '0;
            wr_ptr <= LAST;
            rdy_q  <= 1'b1;
            ov_q   <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
            yn_q   <= '0;
        end else begin
            ov_q  <= 1'b0;
            err_q <= bus.coef_we & in_mac;
            unique case (state)
                IDLE, OUT: begin
                    if (accept) begin
                        state  <= MAC;
                        k      <= '0;
                        wr_ptr <= wr_nxt;
                        rdy_q  <= 1'b0;
                        busy_q <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        rdy_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                MAC: begin
                    if (k == LAST) begin
                        state  <= OUT;
                        rdy_q  <= 1'b1;
                        busy_q <= 1'b0;
                        ov_q   <= 1'b1;
                        yn_q   <= yn_d;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: FIR reference model plus
// directed scenarios and a randomized phase.
module tb_fir_mac_sequencer;
    localparam int WIDTH = 16;
    localparam int N     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.WIDTH(WIDTH), .N(N)) bus ();

    fir_mac_sequencer #(.WIDTH(WIDTH), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    longint hist  [N];
    longint mcoef [N];
    int     mbusy;
    longint expq [$];
    longint seen [$];
    bit     exp_ov, exp_err, exp_busy, exp_ready;
    longint exp_yn;

    task automatic check(string name, longint got, longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // y = floor(sum(c[k]*x[n-k]) / 2^(W-1)), clamped to W-bit signed.
    function automatic longint ref_y();
        longint s, y, hi, lo;
        s = 0;
        for (int i = 0; i < N; i++) s += mcoef[i] * hist[i];
        y  = s >>> (WIDTH - 1);
        hi = (64'sd1 <<< (WIDTH - 1)) - 1;
        lo = -(64'sd1 <<< (WIDTH - 1));
        if (y > hi) y = hi;
        if (y < lo) y = lo;
        return y;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            hist[i]  = 0;
            mcoef[i] = 0;
        end
        mcoef[0]  = (64'sd1 <<< (WIDTH - 1)) - 1;
        mbusy     = 0;
        expq.delete();
        exp_ov    = 0;
        exp_err   = 0;
        exp_busy  = 0;
        exp_ready = 1;
        exp_yn    = 0;
    endtask

    // One clock edge of the reference: a sample costs N busy cycles,
    // writes are refused while busy, result appears as busy ends.
    task automatic model_step();
        bit idle;
        idle    = (mbusy == 0);
        exp_ov  = 0;
        exp_err = 0;
        if (mbusy > 0) begin
            mbusy--;
            if (mbusy == 0) exp_ov = 1;
        end
        if (bus.coef_we) begin
            if (!idle) exp_err = 1;
            else if (int'(bus.coef_addr) < N)
                mcoef[bus.coef_addr] = longint'($signed(bus.coef_data));
        end
        if (bus.in_valid && idle) begin
            for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = longint'($signed(bus.Xn));
            expq.push_back(ref_y());
            mbusy = N;
        end
        exp_busy  = (mbusy > 0);
        exp_ready = (mbusy == 0);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        longint e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_in_ready", longint'(bus.in_ready), 0);
                check("rst_out_valid", longint'(bus.out_valid), 0);
                check("rst_yn", longint'(bus.Yn), 0);
                check("rst_busy", longint'(bus.busy), 0);
                check("rst_coef_err", longint'(bus.coef_err), 0);
            end else begin
                check("out_valid", longint'(bus.out_valid), longint'(exp_ov));
                check("in_ready", longint'(bus.in_ready), longint'(exp_ready));
                check("busy", longint'(bus.busy), longint'(exp_busy));
                check("coef_err", longint'(bus.coef_err), longint'(exp_err));
                if (bus.out_valid) begin
                    if (expq.size() == 0) begin
                        check("yn_unexpected", 0, 1);
                    end else begin
                        e = expq.pop_front();
                        check("yn", longint'(bus.Yn), e);
                        exp_yn = e;
                        seen.push_back(longint'(bus.Yn));
                    end
                end
                check("yn_hold", longint'(bus.Yn), exp_yn);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.Xn        = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("ready_timeout", 0, 1);
    endtask

    task automatic send(longint x);
        bus.Xn       = WIDTH'(x);
        bus.in_valid = 1'b1;
        wait_ready();
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wcoef(int a, logic [WIDTH-1:0] d);
        wait_ready();
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'(a);
        bus.coef_data = d;
        tick();
        bus.coef_we   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || mbusy != 0) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("drain_timeout", 0, 1);
    endtask

    initial begin
        int acc_t [$];
        int n;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_yn", longint'(bus.Yn), 0);
        check("reset_ov", longint'(bus.out_valid), 0);

        // Default coefficients: near pass-through.
        seen.delete();
        send(100);
        send(-50);
        drain();
        check("t1_count", seen.size(), 2);
        check("t1_y0", seen[0], 99);
        check("t1_y1", seen[1], -50);

        // Two-tap moving average.
        do_reset();
        seen.delete();
        wcoef(0, 16'h4000);
        wcoef(1, 16'h4000);
        send(100); send(200); send(-50); send(25); send(0);
        drain();
        check("t2_count", seen.size(), 5);
        check("t2_y0", seen[0], 50);
        check("t2_y1", seen[1], 150);
        check("t2_y2", seen[2], 75);
        check("t2_y3", seen[3], -13);
        check("t2_y4", seen[4], 12);

        // Saturation at both rails.
        do_reset();
        seen.delete();
        for (int i = 0; i < N; i++) wcoef(i, 16'h7FFF);
        repeat (4) send(32767);
        drain();
        check("t3_pos", seen[3], 32767);
        do_reset();
        seen.delete();
        for (int i = 0; i < N; i++) wcoef(i, 16'h7FFF);
        repeat (4) send(-32768);
        drain();
        check("t3_neg", seen[3], -32768);

        // Back-to-back stream with in_valid held.
        do_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.Xn = WIDTH'($urandom);
            wait_ready();
            tick();
            acc_t.push_back(cyc);
        end
        bus.in_valid = 1'b0;
        drain();
        for (int i = 1; i < 8; i++)
            check("t4_gap", acc_t[i] - acc_t[i-1], N + 1);

        // Coefficient write during MAC is refused; in OUT with accept it applies.
        do_reset();
        seen.delete();
        send(200);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'd1;
        bus.coef_data = 16'h4000;
        tick();
        bus.coef_we   = 1'b0;
        drain();
        send(100);
        drain();
        send(300);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("t5_out_seen", longint'(bus.out_valid), 1);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'd1;
        bus.coef_data = 16'h4000;
        bus.Xn        = 16'sd100;
        bus.in_valid  = 1'b1;
        tick();
        idle_inputs();
        drain();
        check("t5_count", seen.size(), 4);
        check("t5_y0", seen[0], 199);
        check("t5_y1", seen[1], 99);
        check("t5_y2", seen[2], 299);
        check("t5_y3", seen[3], 249);

        // Reset in the middle of MAC.
        do_reset();
        wcoef(1, 16'h4000);
        seen.delete();
        send(1234);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_rdy_low", longint'(bus.in_ready), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("t6_no_out", seen.size(), 0);
        send(100);
        drain();
        check("t6_count", seen.size(), 1);
        check("t6_y", seen[0], 99);

        // Randomized traffic with writes landing anywhere.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.Xn        = ($urandom_range(0, 7) == 0) ? 16'sh8000 : WIDTH'($urandom);
            bus.coef_we   = ($urandom_range(0, 5) == 0);
            bus.coef_addr = 2'($urandom_range(0, N - 1));
            bus.coef_data = ($urandom_range(0, 7) == 0) ? 16'h7FFF : WIDTH'($urandom);
            tick();
        end
        idle_inputs();
        drain();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
